wb_commit: RTL and testbench
============================

# wb_commit

Writeback-and-commit stage of the pipelined RISC-V core. It is the write side of the register file's write port. It holds the MEM/WB pipeline register, aligns and extends load data, selects the writeback result, and drives the register-file write port and the WB forwarding path. It also keeps a per-register in-flight scoreboard so decode can detect RAW hazards on results that are not yet written.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `CNTW`, 2, width of each per-register in-flight counter (max `2**CNTW-1` in flight)

Ports:
- `clk` in 1: the only clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `stall` in 1: hold the MEM/WB register.
- `mem_valid` in 1: MEM-stage entry present.
- `mem_regwrite` in 1: entry writes rd.
- `mem_sb` in 1: entry was counted in the scoreboard at issue.
- `mem_rd` in 5: destination register.
- `mem_wbsel` in 2: result select. 0 = ALU, 1 = load, 2 = PC+4, 3 = ALU.
- `mem_funct3` in 3: load type.
- `mem_alu_result` in XLEN: ALU result or load address.
- `mem_load_data` in XLEN: raw aligned word from data memory.
- `mem_pc4` in XLEN: link value.
- `iss_valid` in 1: decode issues an instruction writing `iss_rd`.
- `iss_rd` in 5: issued destination.
- `iss_ready` out 1: issue accepted.
- `rs1`, `rs2` in 5: decode source registers.
- `hazard` out 1: rs1 or rs2 has a pending write.
- `regwrite` out 1: register-file write enable.
- `writebackreg` out 5: write address.
- `data_towrite_mem_wb` out XLEN: write data.
- `fwd_valid` out 1: forward path valid. Equals `regwrite`.

## Operation
- **MEM/WB register.** Captures all `mem_*` inputs at each edge where `stall`=0. When `stall`=1 it holds its contents.
  - A captured entry with `mem_valid`=0 is a bubble: `regwrite`=0 and no scoreboard decrement.
- **Result select.** Uses the registered `wbsel`:
  - ALU result,
  - aligned load (see below),
  - `pc4`.
- **Load alignment** (sub-module `load_align`). Byte offset `off` = `alu_result[1:0]`.
  - LB (000): byte `off`, sign-extended. LBU (100): same byte, zero-extended.
  - LH (001) / LHU (101): halfword selected by `off[1]`, sign-/zero-extended. `off[0]` is ignored.
  - LW (010) and all other codes: full word, offset ignored.
- **Write port.** `regwrite` = valid & regwrite & (rd != 0). x0 is never written.
  - `writebackreg` and `data_towrite_mem_wb` are driven from the MEM/WB register plus the select/align logic.
- **Scoreboard.** One CNTW-bit counter per register x1..x31. The x0 counter does not exist and always reads 0.
  - **Issue.** Increments count[`iss_rd`] when `iss_valid` & `iss_ready` & `iss_rd`!=0.
  - **Issue to x0.** Accepted with no count change.
  - **Ready.** `iss_ready`=0 when count[`iss_rd`] is at maximum and no same-cycle retire of that register occurs. Decode holds issue while `iss_ready`=0.
  - **Retire.** Decrements count[rd] when the WB entry is valid, `sb`=1 and rd!=0, regardless of `regwrite`. Flushed instructions therefore still retire their count.
  - Retire happens once per entry: not repeated while `stall` holds the same entry.
  - **Same register, same cycle** issue and retire: net count unchanged.
  - **Hazard.** `hazard` = (count[`rs1`]!=0) | (count[`rs2`]!=0). Combinational.
  - **Decrement below zero.** Must not occur. Counter saturates at 0; verification flags it as an assertion.

## Timing
- **Reset.** While `rst`=0 at an edge:
  - MEM/WB register is cleared to a bubble, so `regwrite`=0, `writebackreg`=0, `data_towrite_mem_wb`=0, `fwd_valid`=0.
  - All counters are cleared, so `hazard`=0 and `iss_ready`=1.
  - Reset mid-operation discards in-flight entries. Issue is ignored during reset.
- **Latency.** A MEM entry captured at edge N drives the write port during cycle N..N+1. The register file commits it at edge N+1.
- **Scoreboard timing.**
  - Count updates take effect the cycle after issue or retire.
  - `hazard` for a register being retired in the current cycle stays 1 that cycle. Decode obtains the value via forwarding from the WB outputs.
- **Stall.** Outputs are stable while `stall`=1. `regwrite` stays asserted and rewrites the same value, which is harmless.
- **Combinational paths.**
  - `hazard` and `iss_ready` are combinational from `rs1`/`rs2`/`iss_rd` and the counters.
  - No combinational path from `mem_*` to any output.

## Structure
- **Shared package** `riscv_pkg`:
  - `WBSEL_ALU`/`WBSEL_LOAD`/`WBSEL_PC4` constants,
  - load funct3 codes `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`,
  - the MEM/WB entry struct typedef.
- **Sub-module** `load_align`: purely combinational (funct3, off, word) -> XLEN result.
- The scoreboard stays inline.

## Test plan
- **Reset.** Hold `rst`=0 for 2 cycles with `mem_valid`=1. Required: `regwrite`=0, `data_towrite_mem_wb`=0, `hazard`=0, `iss_ready`=1.
- **Load alignment.** `mem_load_data`=0x80F1_7F02, LB at offsets 0..3. Required: 0x00000002, 0x0000007F, 0xFFFFFFF1, 0xFFFFFF80.
  - LHU at offset 2: 0x000080F1. LH at offset 2: 0xFFFF80F1.
- **x0 write.** ALU write to rd=0 with result 0x1234. Required: `regwrite`=0. Issue to x0 leaves `hazard`=0 for `rs1`=0.
- **Scoreboard sequence.** Issue rd=5 three times (CNTW=2). Required: `iss_ready`=0 on the 4th attempt.
  - Then retire one rd=5 entry while issuing rd=5. Required: accepted, count stays 3.
  - Retire all. Required: `hazard` for `rs1`=5 drops the cycle after the last retire.
- **Flush retire.** Entry with `mem_sb`=1, `mem_regwrite`=0, rd=7. Required: no write; count[7] decrements.
- **Stall hold.** Capture rd=9 data 0xDEADBEEF, then assert `stall` for 3 cycles. Required: outputs unchanged and count[9] decremented exactly once.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the core's writeback path: result-select codes,
// load funct3 codes and the control half of the MEM/WB pipeline entry.
package riscv_pkg;

   localparam logic [1:0] WBSEL_ALU  = 2'd0;
   localparam logic [1:0] WBSEL_LOAD = 2'd1;
   localparam logic [1:0] WBSEL_PC4  = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Control fields of a MEM/WB entry; the XLEN-wide data words are kept
   // alongside it so the struct does not depend on the datapath width.
   typedef struct packed {
      logic       valid;
      logic       regwrite;
      logic       sb;
      logic [4:0] rd;
      logic [1:0] wbsel;
      logic [2:0] funct3;
   } mem_wb_entry_t;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from an aligned memory word and
// sign- or zero-extends it according to the load funct3.
module load_align
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      off,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select and extension; unknown funct3 codes fall back to the full word.
   always_comb begin
      byte_sel = word[{off, 3'b000} +: 8];
      half_sel = off[1] ? word[31:16] : word[15:0];
      result   = word;
      case (funct3)
         F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: MEM/WB register, load alignment, result select,
// register-file write port and a per-register in-flight write scoreboard.
module wb_commit
   import riscv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int CNTW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            mem_valid,
   input  logic            mem_regwrite,
   input  logic            mem_sb,
   input  logic [4:0]      mem_rd,
   input  logic [1:0]      mem_wbsel,
   input  logic [2:0]      mem_funct3,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [XLEN-1:0] mem_load_data,
   input  logic [XLEN-1:0] mem_pc4,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   output logic            iss_ready,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            hazard,
   output logic            regwrite,
   output logic [4:0]      writebackreg,
   output logic [XLEN-1:0] data_towrite_mem_wb,
   output logic            fwd_valid
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

   mem_wb_entry_t   entry_reg;
   logic [XLEN-1:0] alu_reg;
   logic [XLEN-1:0] load_reg;
   logic [XLEN-1:0] pc4_reg;
   logic            fresh_reg;   // entry was captured at the last edge (not a stalled repeat)

   logic [CNTW-1:0] count_reg  [1:31];
   logic [CNTW-1:0] count_view [32];
   logic [XLEN-1:0] load_value;
   logic            retire;
   logic            issue_fire;

   // MEM/WB pipeline register; reset leaves a bubble with all-zero data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         entry_reg <= '0;
         alu_reg   <= '0;
         load_reg  <= '0;
         pc4_reg   <= '0;
         fresh_reg <= 1'b0;
      end else if (!stall) begin
         entry_reg <= '{valid: mem_valid, regwrite: mem_regwrite, sb: mem_sb,
                        rd: mem_rd, wbsel: mem_wbsel, funct3: mem_funct3};
         alu_reg   <= mem_alu_result;
         load_reg  <= mem_load_data;
         pc4_reg   <= mem_pc4;
         fresh_reg <= 1'b1;
      end else begin
         fresh_reg <= 1'b0;
      end
   end

   load_align #(.XLEN(XLEN)) u_load_align (
      .funct3 (entry_reg.funct3),
      .off    (alu_reg[1:0]),
      .word   (load_reg),
      .result (load_value)
   );

   // Writeback result select from the registered entry only.
   always_comb begin
      case (entry_reg.wbsel)
         WBSEL_LOAD: data_towrite_mem_wb = load_value;
         WBSEL_PC4:  data_towrite_mem_wb = pc4_reg;
         default:    data_towrite_mem_wb = alu_reg;
      endcase
   end

   assign regwrite     = entry_reg.valid & entry_reg.regwrite & (entry_reg.rd != 5'd0);
   assign writebackreg = entry_reg.rd;
   assign fwd_valid    = regwrite;

   // A stalled entry retires only in its first WB cycle; flushed entries
   // (regwrite=0) still give back their scoreboard slot.
   assign retire     = fresh_reg & entry_reg.valid & entry_reg.sb & (entry_reg.rd != 5'd0);
   assign iss_ready  = (count_view[iss_rd] != CNT_MAX) | (retire & (entry_reg.rd == iss_rd));
   assign issue_fire = iss_valid & iss_ready & (iss_rd != 5'd0);
   assign hazard     = (count_view[rs1] != '0) | (count_view[rs2] != '0);

   // Readable counter view with x0 hard-wired to zero.
   always_comb begin
      count_view[0] = '0;
      for (int i = 1; i < 32; i++) begin
         count_view[i] = count_reg[i];
      end
   end

   // In-flight counters: +1 on accepted issue, -1 on retire, net zero when both hit one register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 1; i < 32; i++) begin
            count_reg[i] <= '0;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (issue_fire && (iss_rd == 5'(i)) && !(retire && (entry_reg.rd == 5'(i)))) begin
               count_reg[i] <= count_reg[i] + CNT_ONE;
            end else if (retire && (entry_reg.rd == 5'(i)) && !(issue_fire && (iss_rd == 5'(i)))
                         && (count_reg[i] != '0)) begin
               count_reg[i] <= count_reg[i] - CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit: stimulus pushes the expected write-port
// response per captured entry; a monitor pops and compares on each cycle,
// and a count-per-register reference model predicts hazard/iss_ready.
module tb_wb_commit;
   import riscv_pkg::*;

   localparam int CMAX = 3;

   logic        clk = 1'b0;
   logic        rst, stall, mem_valid, mem_regwrite, mem_sb;
   logic [4:0]  mem_rd;
   logic [1:0]  mem_wbsel;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_alu_result, mem_load_data, mem_pc4;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic [4:0]  rs1, rs2;
   logic        hazard, regwrite, fwd_valid;
   logic [4:0]  writebackreg;
   logic [31:0] data_towrite_mem_wb;

   wb_commit #(.XLEN(32), .CNTW(2)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_sb(mem_sb),
      .mem_rd(mem_rd), .mem_wbsel(mem_wbsel), .mem_funct3(mem_funct3),
      .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data), .mem_pc4(mem_pc4),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .rs1(rs1), .rs2(rs2), .hazard(hazard),
      .regwrite(regwrite), .writebackreg(writebackreg),
      .data_towrite_mem_wb(data_towrite_mem_wb), .fwd_valid(fwd_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_exp;
   exp_t cur;
   int   n_cmp  = 0;
   int   n_fail = 0;

   // reference model state
   int         cnt[32];
   int         pending[$];
   bit         m_valid, m_sb, m_fresh;
   logic [4:0] m_rd;
   bit         m_ret, m_acc;
   bit         mon_rst, mon_stall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit model_retire();
      return m_fresh && m_valid && m_sb && (m_rd != 5'd0);
   endfunction

   function automatic bit model_ready(input logic [4:0] rd);
      return (rd == 5'd0) || (cnt[rd] < CMAX) || (model_retire() && (m_rd == rd));
   endfunction

   function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [2:0] f3,
                                              input logic [31:0] alu, input logic [31:0] ld,
                                              input logic [31:0] pc4);
      logic [31:0] v;
      int          sh;
      if (sel == 2'd2) return pc4;
      if (sel != 2'd1) return alu;
      case (f3)
         3'b000, 3'b100: begin
            sh = 8 * int'(alu[1:0]);
            v  = (ld >> sh) & 32'hFF;
            if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
         end
         3'b001, 3'b101: begin
            sh = alu[1] ? 16 : 0;
            v  = (ld >> sh) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
         end
         default: v = ld;
      endcase
      return v;
   endfunction

   // Reference model: per-register in-flight counts and the entry sitting in WB.
   always @(posedge clk) begin
      if (!rst) begin
         foreach (cnt[i]) cnt[i] = 0;
         m_valid = 1'b0; m_sb = 1'b0; m_fresh = 1'b0; m_rd = 5'd0;
         pending.delete();
      end else begin
         m_ret = model_retire();
         m_acc = iss_valid && model_ready(iss_rd) && (iss_rd != 5'd0);
         if (m_ret) begin
            chk("sb_no_underflow", 32'(cnt[m_rd] > 0), 32'd1);
            if (cnt[m_rd] > 0) cnt[m_rd]--;
         end
         if (m_acc) begin
            cnt[iss_rd]++;
            pending.push_back(int'(iss_rd));
         end
         if (!stall) begin
            m_valid = mem_valid; m_sb = mem_sb; m_rd = mem_rd; m_fresh = 1'b1;
         end else begin
            m_fresh = 1'b0;
         end
      end
   end

   // Monitor: one comparison set per cycle, sampled on the falling edge.
   initial begin
      last_exp = '{we: 1'b0, rd: 5'd0, data: 32'd0};
      forever begin
         @(posedge clk);
         mon_rst   = rst;
         mon_stall = stall;
         @(negedge clk);
         if (!mon_rst) begin
            chk("reset_regwrite", 32'(regwrite), 32'd0);
            chk("reset_fwd_valid", 32'(fwd_valid), 32'd0);
            chk("reset_wbreg", 32'(writebackreg), 32'd0);
            chk("reset_data", data_towrite_mem_wb, 32'd0);
            last_exp = '{we: 1'b0, rd: 5'd0, data: 32'd0};
         end else begin
            if (mon_stall) begin
               cur = last_exp;
            end else if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL scoreboard_underrun: got DUT entry, required queued expectation at %0t", $time);
               cur = last_exp;
            end else begin
               cur = exp_q.pop_front();
            end
            last_exp = cur;
            chk(mon_stall ? "hold_regwrite" : "regwrite", 32'(regwrite), 32'(cur.we));
            chk("fwd_valid", 32'(fwd_valid), 32'(cur.we));
            if (cur.we) begin
               chk(mon_stall ? "hold_wbreg" : "wbreg", 32'(writebackreg), 32'(cur.rd));
               chk(mon_stall ? "hold_data" : "data", data_towrite_mem_wb, cur.data);
            end
         end
         chk("hazard", 32'(hazard), 32'((cnt[rs1] != 0) || (cnt[rs2] != 0)));
         chk("iss_ready", 32'(iss_ready), 32'(model_ready(iss_rd)));
      end
   end

   task automatic set_idle();
      stall = 1'b0; mem_valid = 1'b0; mem_regwrite = 1'b0; mem_sb = 1'b0; mem_rd = 5'd0;
      mem_wbsel = 2'd0; mem_funct3 = 3'd0; mem_alu_result = 32'd0; mem_load_data = 32'd0;
      mem_pc4 = 32'd0; iss_valid = 1'b0; iss_rd = 5'd0;
   endtask

   task automatic set_mem(input bit v, input bit we, input bit sb, input logic [4:0] rd,
                          input logic [1:0] sel, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] ld);
      mem_valid = v; mem_regwrite = we; mem_sb = sb; mem_rd = rd; mem_wbsel = sel;
      mem_funct3 = f3; mem_alu_result = alu; mem_load_data = ld; mem_pc4 = alu + 32'd4;
   endtask

   task automatic drop_pending(input logic [4:0] rd);
      int idx[$];
      idx = pending.find_first_index(x) with (x == int'(rd));
      if (idx.size() > 0) pending.delete(idx[0]);
   endtask

   // Queue the expected response for the current inputs, then advance one cycle.
   task automatic tick_exp(input bit use_ovr, input logic [31:0] ovr);
      exp_t e;
      if (rst && !stall) begin
         e.we   = mem_valid && mem_regwrite && (mem_rd != 5'd0);
         e.rd   = mem_rd;
         e.data = use_ovr ? ovr : ref_result(mem_wbsel, mem_funct3, mem_alu_result,
                                             mem_load_data, mem_pc4);
         exp_q.push_back(e);
      end
      @(negedge clk);
      #1;
   endtask

   task automatic tick();
      tick_exp(1'b0, 32'd0);
   endtask

   logic [31:0] lb_exp [4];

   initial begin
      rst = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
      set_idle();
      lb_exp[0] = 32'h0000_0002; lb_exp[1] = 32'h0000_007F;
      lb_exp[2] = 32'hFFFF_FFF1; lb_exp[3] = 32'hFFFF_FF80;

      // reset with live inputs
      set_mem(1, 1, 1, 5'd3, WBSEL_ALU, 3'd0, 32'h1111, 32'd0);
      iss_valid = 1'b1; iss_rd = 5'd4; rs1 = 5'd4;
      tick(); tick();
      chk("reset_iss_ready", 32'(iss_ready), 32'd1);
      chk("reset_hazard", 32'(hazard), 32'd0);
      rst = 1'b1; set_idle(); rs1 = 5'd0;
      tick();

      // load alignment
      for (int o = 0; o < 4; o++) begin
         set_mem(1, 1, 0, 5'(10 + o), WBSEL_LOAD, F3_LB, 32'h1000 + 32'(o), 32'h80F1_7F02);
         tick_exp(1'b1, lb_exp[o]);
      end
      set_mem(1, 1, 0, 5'd14, WBSEL_LOAD, F3_LHU, 32'h1002, 32'h80F1_7F02);
      tick_exp(1'b1, 32'h0000_80F1);
      set_mem(1, 1, 0, 5'd15, WBSEL_LOAD, F3_LH, 32'h1002, 32'h80F1_7F02);
      tick_exp(1'b1, 32'hFFFF_80F1);

      // x0 write and x0 issue
      set_mem(1, 1, 0, 5'd0, WBSEL_ALU, 3'd0, 32'h1234, 32'd0);
      iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
      tick();
      set_idle();
      tick();
      chk("x0_regwrite", 32'(regwrite), 32'd0);
      chk("x0_hazard", 32'(hazard), 32'd0);

      // scoreboard saturation and same-cycle issue/retire
      rs1 = 5'd5; rs2 = 5'd0;
      iss_valid = 1'b1; iss_rd = 5'd5;
      for (int k = 0; k < 3; k++) tick();
      chk("issue4_ready", 32'(iss_ready), 32'd0);
      tick();
      iss_valid = 1'b0;
      set_mem(1, 1, 1, 5'd5, WBSEL_ALU, 3'd0, 32'h55, 32'd0);
      drop_pending(5'd5);
      tick();
      set_idle(); iss_valid = 1'b1; iss_rd = 5'd5;
      #1 chk("issue_while_retire_ready", 32'(iss_ready), 32'd1);
      tick();
      chk("count_stays_3_ready", 32'(iss_ready), 32'd0);
      iss_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_mem(1, 1, 1, 5'd5, WBSEL_PC4, 3'd0, 32'h500 + 32'(k), 32'd0);
         drop_pending(5'd5);
         tick();
      end
      set_idle();
      #1 chk("hazard_during_last_retire", 32'(hazard), 32'd1);
      tick();
      chk("hazard_after_last_retire", 32'(hazard), 32'd0);

      // flushed entry still retires
      rs1 = 5'd7; iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      iss_valid = 1'b0;
      set_mem(1, 0, 1, 5'd7, WBSEL_ALU, 3'd0, 32'h777, 32'd0);
      drop_pending(5'd7);
      tick();
      set_idle();
      #1 chk("flush_regwrite", 32'(regwrite), 32'd0);
      tick();
      chk("flush_retired_hazard", 32'(hazard), 32'd0);

      // stall holds outputs and retires once
      rs1 = 5'd9; iss_valid = 1'b1; iss_rd = 5'd9;
      tick(); tick();
      iss_valid = 1'b0;
      set_mem(1, 1, 1, 5'd9, WBSEL_ALU, 3'd0, 32'hDEAD_BEEF, 32'd0);
      drop_pending(5'd9);
      tick();
      set_mem(1, 1, 0, 5'd20, WBSEL_ALU, 3'd0, 32'h1111_2222, 32'd0);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_data", data_towrite_mem_wb, 32'hDEAD_BEEF);
         chk("stall_hazard_count1", 32'(hazard), 32'd1);
      end
      set_idle();
      tick();
      set_mem(1, 1, 1, 5'd9, WBSEL_ALU, 3'd0, 32'h9999, 32'd0);
      drop_pending(5'd9);
      tick();
      set_idle();
      tick();
      chk("stall_final_hazard", 32'(hazard), 32'd0);

      // randomized traffic with a mid-run reset
      pending.delete();
      for (int c = 0; c < 400; c++) begin
         if (c == 200) begin
            rst = 1'b0; set_idle();
            tick(); tick();
            rst = 1'b1;
         end
         stall        = ($urandom_range(0, 4) == 0);
         iss_valid    = 1'($urandom_range(0, 1));
         iss_rd       = 5'($urandom_range(0, 7));
         rs1          = 5'($urandom_range(0, 7));
         rs2          = 5'($urandom_range(0, 7));
         mem_valid    = ($urandom_range(0, 9) < 8);
         mem_regwrite = ($urandom_range(0, 19) < 17);
         if (!stall && mem_valid && pending.size() > 0 && $urandom_range(0, 1) == 1) begin
            mem_sb = 1'b1;
            mem_rd = 5'(pending.pop_front());
         end else begin
            mem_sb = 1'b0;
            mem_rd = 5'($urandom_range(0, 31));
         end
         mem_wbsel      = 2'($urandom_range(0, 3));
         mem_funct3     = 3'($urandom_range(0, 7));
         mem_alu_result = $urandom;
         mem_load_data  = $urandom;
         mem_pc4        = $urandom;
         tick();
      end
      set_idle();
      tick(); tick();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
